alarm_scheduler: RTL
====================

# alarm_scheduler

Multi-slot alarm controller that sits in front of the alarm ring logic and the shared minigame datapath. It stores up to NUM_SLOTS alarm times, watches the BCD wall-clock, and queues alarms that fire. It grants the single minigame resource to one alarm at a time and handles snooze with BCD wrap-around. Its state output uses the same one-hot-style codes already used by the alarm path (000/001/010/100), so existing display and minigame logic can consume it unchanged.

## Interface
- NUM_SLOTS, 4, number of programmable alarm slots (2..8)
- SNOOZE_MIN, 5, snooze delay in minutes (1..59)
- MAX_SNOOZE, 3, snoozes allowed per firing; further snooze requests are ignored
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- enable  in  1  alarm master switch (SPDT4 level)
- current  in  16  wall-clock time, BCD HH:MM, {H1,H0,M1,M0}
- wr_en  in  1  slot write strobe
- wr_slot  in  $clog2(NUM_SLOTS)  slot index to write
- wr_time  in  16  BCD alarm time to write
- wr_arm  in  1  armed bit written with wr_time
- push_m  in  1  user acknowledge; starts the minigame
- snooze  in  1  user snooze request
- game_done  in  1  one-cycle pulse from the minigame on completion
- alarm_state  out  3  000 IDLE, 001 ARMED, 010 RING, 100 GAME
- ring  out  1  high in RING
- game_grant  out  1  high in GAME; enables the minigame datapath
- active_slot  out  $clog2(NUM_SLOTS)  slot being serviced (0 when none)
- pending  out  NUM_SLOTS  queued fired slots
- slot_armed  out  NUM_SLOTS  armed bit per slot
- snooze_cnt  out  2  snoozes used on the current firing

## Operation
- Reset: all slots cleared to 00:00 and disarmed. pending, fired, snooze state and snooze_cnt = 0. alarm_state = 000. ring, game_grant and active_slot = 0.
- Slot match: slot i matches when slot_armed[i], current == slot_time[i], and fired[i] == 0. A match sets pending[i] and fired[i]. fired[i] clears once current != slot_time[i], so each slot fires at most once per minute.
- FSM, evaluated only while enable = 1:
  - IDLE → ARMED.
  - ARMED → RING when pending != 0 or a match occurs this cycle. active_slot is loaded with the lowest-index set bit.
  - RING → GAME on push_m.
  - RING → ARMED on snooze when snooze_cnt < MAX_SNOOZE. This clears pending[active_slot], loads snooze_time = current + SNOOZE_MIN, sets snooze_valid, stores snooze_slot = active_slot, and increments snooze_cnt.
  - GAME → ARMED on game_done. This clears pending[active_slot] and snooze_cnt.
- Snooze match: when snooze_valid and current == snooze_time, set pending[snooze_slot] and clear snooze_valid. snooze_cnt is kept, so it counts across re-rings of the same firing.
- enable = 0 in any state: next state IDLE. pending, fired, snooze_valid and snooze_cnt are cleared. Slot contents are kept.
- Writes: wr_en updates slot_time and slot_armed in any state. Writing wr_arm = 0 clears that slot's pending bit, except for the slot currently in RING or GAME, which finishes its service.
- BCD add: M + SNOOZE_MIN; if the result is ≥ 60, subtract 60 and carry 1 hour. Hours wrap 23 → 00. Every digit stays valid BCD.

## Timing
- All state, pending and outputs are registered.
- Match at cycle N: pending and alarm_state = RING are visible at cycle N+1.
- ring and game_grant are decoded from the registered state, with no extra latency.
- Simultaneous events:
  - push_m and snooze in the same cycle: push_m wins.
  - game_done and enable falling in the same cycle: IDLE wins.
  - Multiple matches in one cycle: all are queued and serviced lowest index first. After game_done, the next pending slot enters RING on the following cycle.
  - A match on the slot currently in service is absorbed (its pending bit is already set).
- push_m outside RING, snooze outside RING, and game_done outside GAME are ignored.
- Reset mid-operation: immediate return to reset values, regardless of clock.

## Structure
- Package alarm_pkg:
  - state codes ST_IDLE/ST_ARMED/ST_RING/ST_GAME (3'b000/001/010/100)
  - the BCD time type (16-bit, 4 digits)
  - constants MIN_PER_HOUR = 60 and HOURS_PER_DAY = 24
- Sub-module bcd_time_add: combinational HH:MM plus minutes, with wrap. It is reused by later display blocks.
- Top level holds the slot register file, the fired/pending vectors, the priority encoder and the FSM.

## Test plan
- Program slot 2 = 07:30 armed; drive current 07:29 → 07:30 → alarm_state = 010 one cycle later, active_slot = 2. Pulse push_m → 100. Pulse game_done → 001; pending = 0.
- Slots 1 and 3 both = 12:00; current = 12:00 → pending = 4'b1010, slot 1 serviced first. After game_done, RING with active_slot = 3 on the next cycle.
- RING at 23:58 with SNOOZE_MIN = 5; pulse snooze → 001, snooze_cnt = 1, snooze_time = 00:03. current = 00:03 → RING again with the same slot.
- Snooze three times, then snooze a fourth time → state stays 010, snooze_cnt = 3. push_m and snooze together → 100.
- Hold current = 06:00 matching slot 0 through a full service → no re-fire within the minute. current 06:01 → 06:00 → fires again.
- Drop enable in GAME → 000 next cycle, pending = 0, slot contents intact. Assert reset mid-RING → all outputs 0 asynchronously.

Source files
------------

// File: rtl/alarm_pkg.sv
// alarm_pkg: shared types and constants for the alarm scheduler and the
// display blocks that reuse its BCD time arithmetic.
//   state_t    : alarm path state codes (one-hot style, IDLE is all zeros)
//   bcd_time_t : HH:MM as four BCD digits {h1,h0,m1,m0}
package alarm_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'b000,
    ST_ARMED = 3'b001,
    ST_RING  = 3'b010,
    ST_GAME  = 3'b100
  } state_t;

  typedef struct packed {
    logic [3:0] h1;
    logic [3:0] h0;
    logic [3:0] m1;
    logic [3:0] m0;
  } bcd_time_t;

  localparam int MIN_PER_HOUR  = 60;
  localparam int HOURS_PER_DAY = 24;

endpackage

// File: rtl/alarm_scheduler_if.sv
// alarm_scheduler_if: user/clock/minigame signals of the alarm scheduler.
//   master : drives enable, wall clock, slot writes, push_m/snooze, game_done
//   slave  : the scheduler; returns state, ring, grant, slot/pending status
interface alarm_scheduler_if
  import alarm_pkg::*;
#(
  parameter int NUM_SLOTS = 4
);
  localparam int SLOT_W = $clog2(NUM_SLOTS);

  logic                 enable;
  bcd_time_t            current;
  logic                 wr_en;
  logic [SLOT_W-1:0]    wr_slot;
  bcd_time_t            wr_time;
  logic                 wr_arm;
  logic                 push_m;
  logic                 snooze;
  logic                 game_done;

  logic [2:0]           alarm_state;
  logic                 ring;
  logic                 game_grant;
  logic [SLOT_W-1:0]    active_slot;
  logic [NUM_SLOTS-1:0] pending;
  logic [NUM_SLOTS-1:0] slot_armed;
  logic [1:0]           snooze_cnt;

  modport master (
    output enable, current, wr_en, wr_slot, wr_time, wr_arm, push_m, snooze, game_done,
    input  alarm_state, ring, game_grant, active_slot, pending, slot_armed, snooze_cnt
  );

  modport slave (
    input  enable, current, wr_en, wr_slot, wr_time, wr_arm, push_m, snooze, game_done,
    output alarm_state, ring, game_grant, active_slot, pending, slot_armed, snooze_cnt
  );
endinterface

// File: rtl/bcd_time_add.sv
// bcd_time_add: combinational BCD HH:MM + add_min (0..59) minutes.
//   t_in    : BCD time in
//   add_min : binary minutes to add
//   t_out   : BCD result; minutes carry into hours, hours wrap 23 -> 00
module bcd_time_add
  import alarm_pkg::*;
(
  input  bcd_time_t  t_in,
  input  logic [5:0] add_min,
  output bcd_time_t  t_out
);
  logic [6:0] min_bin, min_sum;
  logic [4:0] hr_bin, hr_sum;

  always_comb begin
    min_bin = 7'(t_in.m1) * 7'd10 + 7'(t_in.m0);
    hr_bin  = 5'(t_in.h1) * 5'd10 + 5'(t_in.h0);
    min_sum = min_bin + 7'(add_min);
    hr_sum  = hr_bin;
    if (min_sum >= 7'(MIN_PER_HOUR)) begin
      min_sum = min_sum - 7'(MIN_PER_HOUR);
      hr_sum  = hr_bin + 5'd1;
    end
    if (hr_sum >= 5'(HOURS_PER_DAY))
      hr_sum = hr_sum - 5'(HOURS_PER_DAY);
    t_out.h1 = 4'(hr_sum / 5'd10);
    t_out.h0 = 4'(hr_sum % 5'd10);
    t_out.m1 = 4'(min_sum / 7'd10);
    t_out.m0 = 4'(min_sum % 7'd10);
  end
endmodule

// File: rtl/alarm_scheduler.sv
// alarm_scheduler: multi-slot alarm controller with a fire queue, single
// minigame grant and BCD snooze.
//   clk, reset : clock, async active-high reset
//   bus        : alarm_scheduler_if.slave (controls in, state/status out)
module alarm_scheduler
  import alarm_pkg::*;
#(
  parameter int NUM_SLOTS  = 4,
  parameter int SNOOZE_MIN = 5,
  parameter int MAX_SNOOZE = 3
) (
  input  logic             clk,
  input  logic             reset,
  alarm_scheduler_if.slave bus
);
  localparam int SLOT_W = $clog2(NUM_SLOTS);

  state_t               state_q, state_d;
  bcd_time_t            slot_time_q [NUM_SLOTS];
  bcd_time_t            slot_time_d [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] slot_armed_q, slot_armed_d;
  logic [NUM_SLOTS-1:0] fired_q, fired_d;
  logic [NUM_SLOTS-1:0] pending_q, pending_d;
  logic [SLOT_W-1:0]    active_slot_q, active_slot_d;
  logic [SLOT_W-1:0]    snooze_slot_q, snooze_slot_d;
  logic                 snooze_valid_q, snooze_valid_d;
  bcd_time_t            snooze_time_q, snooze_time_d;
  logic [1:0]           snooze_cnt_q, snooze_cnt_d;

  bcd_time_t            snooze_target;
  logic [NUM_SLOTS-1:0] eq, match, set_vec, wr_clr, req;
  logic [SLOT_W-1:0]    first;
  logic                 in_service;

  bcd_time_add u_snooze_add (
    .t_in   (bus.current),
    .add_min(6'(SNOOZE_MIN)),
    .t_out  (snooze_target)
  );

  always_comb begin
    in_service = (state_q == ST_RING) || (state_q == ST_GAME);
    for (int i = 0; i < NUM_SLOTS; i++) begin
      eq[i]    = (bus.current == slot_time_q[i]);
      match[i] = slot_armed_q[i] && eq[i] && !fired_q[i];
    end
    set_vec = match;
    if (snooze_valid_q && bus.current == snooze_time_q)
      set_vec[snooze_slot_q] = 1'b1;
    // Disarming drops a queued slot, but never the one being serviced.
    wr_clr = '0;
    if (bus.wr_en && !bus.wr_arm && !(in_service && bus.wr_slot == active_slot_q))
      wr_clr[bus.wr_slot] = 1'b1;
    req = (pending_q | set_vec) & ~wr_clr;
    // Lowest set index wins: scan high to low, last hit is kept.
    first = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--)
      if (req[i]) first = SLOT_W'(i);
  end

  always_comb begin
    state_d        = state_q;
    slot_time_d    = slot_time_q;
    slot_armed_d   = slot_armed_q;
    fired_d        = eq & (fired_q | match);
    pending_d      = req;
    active_slot_d  = active_slot_q;
    snooze_slot_d  = snooze_slot_q;
    snooze_valid_d = snooze_valid_q && !(bus.current == snooze_time_q);
    snooze_time_d  = snooze_time_q;
    snooze_cnt_d   = snooze_cnt_q;

    if (bus.wr_en && int'(bus.wr_slot) < NUM_SLOTS) begin
      slot_time_d[bus.wr_slot]  = bus.wr_time;
      slot_armed_d[bus.wr_slot] = bus.wr_arm;
    end

    case (state_q)
      ST_IDLE:  state_d = ST_ARMED;
      ST_ARMED: if (req != '0) begin
        state_d       = ST_RING;
        active_slot_d = first;
      end
      ST_RING: begin
        if (bus.push_m) begin
          state_d = ST_GAME;
        end else if (bus.snooze && snooze_cnt_q < 2'(MAX_SNOOZE)) begin
          state_d                  = ST_ARMED;
          pending_d[active_slot_q] = 1'b0;
          snooze_time_d            = snooze_target;
          snooze_valid_d           = 1'b1;
          snooze_slot_d            = active_slot_q;
          snooze_cnt_d             = snooze_cnt_q + 2'd1;
          active_slot_d            = '0;
        end
      end
      ST_GAME: if (bus.game_done) begin
        state_d                  = ST_ARMED;
        pending_d[active_slot_q] = 1'b0;
        snooze_cnt_d             = '0;
        active_slot_d            = '0;
      end
      default: state_d = ST_IDLE;
    endcase

    // Master switch off overrides everything except slot contents.
    if (!bus.enable) begin
      state_d        = ST_IDLE;
      pending_d      = '0;
      fired_d        = '0;
      snooze_valid_d = 1'b0;
      snooze_cnt_d   = '0;
      active_slot_d  = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      for (int i = 0; i < NUM_SLOTS; i++) slot_time_q[i] <= '0;
      slot_armed_q   <= '0;
      fired_q        <= '0;
      pending_q      <= '0;
      active_slot_q  <= '0;
      snooze_slot_q  <= '0;
      snooze_valid_q <= 1'b0;
      snooze_time_q  <= '0;
      snooze_cnt_q   <= '0;
    end else begin
      state_q        <= state_d;
      slot_time_q    <= slot_time_d;
      slot_armed_q   <= slot_armed_d;
      fired_q        <= fired_d;
      pending_q      <= pending_d;
      active_slot_q  <= active_slot_d;
      snooze_slot_q  <= snooze_slot_d;
      snooze_valid_q <= snooze_valid_d;
      snooze_time_q  <= snooze_time_d;
      snooze_cnt_q   <= snooze_cnt_d;
    end
  end

  assign bus.alarm_state = state_q;
  assign bus.ring        = (state_q == ST_RING);
  assign bus.game_grant  = (state_q == ST_GAME);
  assign bus.active_slot = active_slot_q;
  assign bus.pending     = pending_q;
  assign bus.slot_armed  = slot_armed_q;
  assign bus.snooze_cnt  = snooze_cnt_q;
endmodule
